// File: rtl/tt_sweep_ctrl.sv
// Truth-table extraction controller: sweeps a function-under-test through every
// input minterm and assembles its truth table, on-set size and expected-match flag.
module tt_sweep_ctrl #(
  parameter int N_IN    = 7,
  parameter int DUT_LAT = 0,
  localparam int TT_W   = 2**N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TT_W-1:0]   expected,
  output logic [N_IN-1:0]   stim,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   tt,
  output logic [N_IN:0]     ones_count,
  output logic              match
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN} state_t;

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t            state, state_nx;
  logic [TT_W-1:0]   expected_q;
  logic [N_IN-1:0]   cap_idx;
  logic              cap_vld;
  logic              drive_vld;
  logic              final_cap;
  logic [TT_W-1:0]   tt_cap;

  assign drive_vld = (state == DRIVE);

  // Index/valid pipeline matches the FUT latency so each dut_out lands on its own minterm.
  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign cap_idx = stim;
      assign cap_vld = drive_vld;
    end else begin : g_lat
      logic [N_IN-1:0]    idx_q [DUT_LAT];
      logic [DUT_LAT-1:0] vld_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned s = 0; s < DUT_LAT; s++) idx_q[s] <= '0;
          vld_q <= '0;
        end else begin
          idx_q[0] <= stim;
          vld_q[0] <= drive_vld;
          for (int unsigned s = 1; s < DUT_LAT; s++) begin
            idx_q[s] <= idx_q[s-1];
            vld_q[s] <= vld_q[s-1];
          end
        end
      end

      assign cap_idx = idx_q[DUT_LAT-1];
      assign cap_vld = vld_q[DUT_LAT-1];
    end
  endgenerate

  assign final_cap = cap_vld && (cap_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The sweep ends on the last capture rather than a drain counter, so DRAIN spans DUT_LAT cycles.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DRIVE;
      DRIVE: begin
        if (final_cap)              state_nx = IDLE;
        else if (stim == LAST_IDX)  state_nx = DRAIN;
      end
      DRAIN:   if (final_cap) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    tt_cap = tt;
    if (cap_vld) tt_cap[cap_idx] = dut_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim       <= '0;
      tt         <= '0;
      ones_count <= '0;
      expected_q <= '0;
      done       <= 1'b0;
      match      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        stim <= '0;
        if (start) begin
          expected_q <= expected;
          tt         <= '0;
          ones_count <= '0;
          match      <= 1'b0;
        end
      end else begin
        if (cap_vld) begin
          tt         <= tt_cap;
          ones_count <= ones_count + {{N_IN{1'b0}}, dut_out};
        end
        if (final_cap) begin
          done  <= 1'b1;
          match <= (tt_cap == expected_q);
          stim  <= '0;
        end else if (state == DRIVE && stim != LAST_IDX) begin
          stim <= stim + N_IN'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: zero-latency and two-cycle-latency instances checked every
// cycle against a sweep-offset model, plus literal expectations for the directed cases.
module tb_tt_sweep_ctrl;
  localparam int N = 7;
  localparam int W = 128;
  localparam logic [W-1:0] ALT = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [W-1:0] AND_TT = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] expected = '0;
  logic [N-1:0] stim0, stim2;
  logic out0, out2, busy0, busy2, done0, done2, match0, match2;
  logic [W-1:0] tt0, tt2;
  logic [N:0] ones0, ones2;
  int mode = 0;
  logic [W-1:0] rnd_tbl = '0;
  int tests = 0, fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  tt_sweep_ctrl #(.N_IN(7), .DUT_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .stim(stim0),
    .dut_out(out0), .busy(busy0), .done(done0), .tt(tt0), .ones_count(ones0), .match(match0));

  tt_sweep_ctrl #(.N_IN(7), .DUT_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .stim(stim2),
    .dut_out(out2), .busy(busy2), .done(done2), .tt(tt2), .ones_count(ones2), .match(match2));

  function automatic logic fut(input int m, input logic [N-1:0] x);
    case (m)
      0: return x[0];
      1: return 1'b0;
      2: return 1'b1;
      3: return &x;
      4: return ($countones(x) >= 4);
      default: return rnd_tbl[x];
    endcase
  endfunction

  function automatic logic [W-1:0] table_of(input int m);
    logic [W-1:0] t;
    for (int i = 0; i < W; i++) t[i] = fut(m, 7'(i));
    return t;
  endfunction

  assign out0 = fut(mode, stim0);
  logic p1 = 1'b0, p2 = 1'b0;
  always @(posedge clk) begin
    p1 <= fut(mode, stim2);
    p2 <= p1;
  end
  assign out2 = p2;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: each instance tracked by its offset from the acceptance edge.
  int lat_of [2] = '{0, 2};
  bit m_act [2], m_done [2], m_match [2];
  int m_t [2], m_ones [2];
  logic [W-1:0] m_tbl [2], m_exp [2], m_tt [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 0;
      if (!rst_n) begin
        m_act[d] = 0; m_t[d] = 0; m_tt[d] = '0; m_ones[d] = 0; m_match[d] = 0; m_exp[d] = '0;
      end else if (m_act[d]) begin
        m_t[d]++;
        if (m_t[d] == W + lat_of[d]) begin
          m_act[d] = 0; m_done[d] = 1; m_tt[d] = m_tbl[d];
          m_match[d] = (m_tbl[d] == m_exp[d]);
        end else begin
          logic [W-1:0] one;
          int n;
          one = 1;
          n = m_t[d] - lat_of[d];
          m_tt[d] = (n <= 0) ? '0 : (m_tbl[d] & ((one << n) - one));
        end
        m_ones[d] = $countones(m_tt[d]);
      end else if (start) begin
        m_act[d] = 1; m_t[d] = 0; m_tbl[d] = table_of(mode); m_exp[d] = expected;
        m_tt[d] = '0; m_ones[d] = 0; m_match[d] = 0;
      end
    end
  end

  task automatic cmp_one(input int d, input logic [N-1:0] s, input logic b, input logic dn,
                         input logic [W-1:0] t, input logic [N:0] o, input logic mt);
    int es;
    es = !m_act[d] ? 0 : (m_t[d] < W ? m_t[d] : W - 1);
    check($sformatf("dut%0d.stim", d), s, es);
    check($sformatf("dut%0d.busy", d), b, m_act[d]);
    check($sformatf("dut%0d.done", d), dn, m_done[d]);
    check($sformatf("dut%0d.tt", d), t, m_tt[d]);
    check($sformatf("dut%0d.ones", d), o, m_ones[d]);
    check($sformatf("dut%0d.match", d), mt, m_match[d]);
  endtask

  always @(negedge clk) if (chk_en) begin
    cmp_one(0, stim0, busy0, done0, tt0, ones0, match0);
    cmp_one(1, stim2, busy2, done2, tt2, ones2, match2);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy0 || busy2) && c < 500) begin tick(); c++; end
    check("idle_reached", busy0 | busy2, 1'b0);
  endtask

  // Entered 2 time units after an edge; returns the same phase after both instances finish.
  task automatic run_sweep(input int m, input logic [W-1:0] exp,
                           output int d0, output int d2, output int b2);
    int c;
    mode = m; expected = exp; start = 1'b1;
    @(posedge clk);
    c = 0; d0 = -1; d2 = -1; b2 = 0;
    #1 if (busy2) b2++;
    #1 start = 1'b0;
    while ((d0 < 0 || d2 < 0) && c < 400) begin
      @(posedge clk); c++;
      #1;
      if (done0 && d0 < 0) d0 = c;
      if (done2 && d2 < 0) d2 = c;
      if (busy2) b2++;
      #1;
    end
    check("sweep_completed", (d0 >= 0 && d2 >= 0), 1'b1);
  endtask

  initial begin
    int d0, d2, b2, c, first, second, nd;
    logic [W-1:0] maj, flip;

    check("model_and_table", table_of(3), AND_TT);
    check("model_x0_table", table_of(0), ALT);
    @(posedge clk); #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy0, 1'b0);
    check("rst_tt", tt0, '0);
    check("rst_ones", ones0, '0);
    check("rst_match", match0, 1'b0);
    #1 rst_n = 1'b1;
    tick();

    run_sweep(0, ALT, d0, d2, b2);
    check("id_done_lat0", d0, 128);
    check("id_done_lat2", d2, 130);
    check("id_busy_lat2", b2, 130);
    check("id_tt", tt0, ALT);
    check("id_ones", ones0, 64);
    check("id_match", match0, 1'b1);
    check("id_tt_lat2", tt2, ALT);

    run_sweep(1, '0, d0, d2, b2);
    check("zero_tt", tt0, '0);
    check("zero_ones", ones0, 0);
    check("zero_match", match0, 1'b1);

    run_sweep(2, '0, d0, d2, b2);
    check("one_tt", tt0, '1);
    check("one_ones", ones0, 128);
    check("one_match", match0, 1'b0);
    check("one_ones_lat2", ones2, 128);

    run_sweep(3, '0, d0, d2, b2);
    check("and_tt", tt0, AND_TT);
    check("and_ones", ones0, 1);

    maj = '0;
    for (int i = 0; i < W; i++) maj[i] = ($countones(i) >= 4);
    run_sweep(4, maj, d0, d2, b2);
    check("maj_match", match0, 1'b1);
    check("maj_ones", ones0, 64);
    flip = '0;
    flip[$urandom_range(0, W - 1)] = 1'b1;
    run_sweep(4, maj ^ flip, d0, d2, b2);
    check("maj_flip_match", match0, 1'b0);
    check("maj_flip_match_lat2", match2, 1'b0);

    for (int r = 0; r < 5; r++) begin
      rnd_tbl = {$urandom(), $urandom(), $urandom(), $urandom()};
      flip = '0;
      flip[$urandom_range(0, W - 1)] = 1'b1;
      repeat ($urandom_range(0, 5)) tick();
      run_sweep(5, ($urandom_range(0, 1) == 1) ? rnd_tbl : (rnd_tbl ^ flip), d0, d2, b2);
    end

    // Reset in the middle of a sweep.
    mode = 0; expected = ALT; start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (stim0 != 7'd50 && c < 200) begin @(posedge clk); #1; c++; end
    check("reach_stim50", stim0, 50);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_stim", stim0, '0);
    check("mid_rst_tt", tt0, '0);
    check("mid_rst_ones", ones0, '0);
    check("mid_rst_match", match0, 1'b0);
    check("mid_rst_busy_lat2", busy2, 1'b0);
    #1 rst_n = 1'b1;
    nd = 0;
    repeat (200) begin @(posedge clk); #1; if (done0 || done2) nd++; #1; end
    check("no_done_after_rst", nd, 0);
    run_sweep(0, ALT, d0, d2, b2);
    check("post_rst_match", match0, 1'b1);
    check("post_rst_done", d0, 128);

    // Start pulse and expected change while busy must be ignored.
    mode = 0; expected = ALT; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    start = 1'b1; expected = '0;
    tick();
    start = 1'b0;
    wait_idle();
    check("busy_ign_match", match0, 1'b1);
    check("busy_ign_tt", tt0, ALT);
    check("busy_ign_match_lat2", match2, 1'b1);

    // Start held across done: back-to-back sweeps.
    mode = 0; expected = ALT; start = 1'b1;
    first = -1; second = -1; c = 0;
    while (second < 0 && c < 600) begin
      @(posedge clk); c++;
      #1;
      if (done0) begin
        if (first < 0) first = c;
        else second = c;
      end
      #1;
    end
    start = 1'b0;
    check("b2b_spacing", second - first, 129);
    wait_idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
